spart_rx_unit: RTL

- Receive datapath of the SPART.
- Deserializes the asynchronous rxd line using the 16x baud enable from the baud generator.
- Buffers received bytes in a small first-word-fall-through FIFO.
- Presents the head byte, rda and error flags to the SPART bus interface, which services iocs/iorw/ioaddr=00 reads from the driver.

---
 rtl/spart_rx_unit.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/spart_rx_unit.sv
// spart_rx_unit: SPART receive datapath.
// Oversampled asynchronous receiver feeding a small first-word-fall-through FIFO.
// The head byte, rda and the sticky error flags go to the bus interface.
// Optional build macro SPART_RX_GLITCH_FILTER_EN: each bit is the 2-of-3 majority
// of the samples at ticks 7, 8 and 9 of the bit period instead of a single tick-8 sample.
module spart_rx_unit #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 rxd,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
`ifdef SPART_RX_GLITCH_FILTER_EN
  // The majority vote needs the tick after the centre sample, so the start decision is one tick later.
  localparam logic [TICK_W-1:0] START_TICK = TICK_W'(OVERSAMPLE / 2);
`else
  localparam logic [TICK_W-1:0] START_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
`endif
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_err_q, overrun_err_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic rxs;
  logic bit_val;
  logic push;
  logic pop;
  logic set_frame;
  logic set_overrun;
  logic fifo_full;
  logic fifo_empty;

  assign rxs        = sync_q[1];
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign pop        = rd_en && !fifo_empty;

  // Two-stage synchronizer for the asynchronous serial line.
  always_comb begin
    sync_d = {sync_q[0], rxd};
  end

`ifdef SPART_RX_GLITCH_FILTER_EN
  logic [1:0] hist_q, hist_d;

  // Keep the two previous tick samples so the current tick can complete a 2-of-3 vote.
  always_comb begin
    hist_d = hist_q;
    if (enable) begin
      hist_d = {hist_q[0], rxs};
    end
    bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
  end

  // History register; preset high to match the idle line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  // Without the filter the decision is the single synchronized sample at the decision tick.
  always_comb begin
    bit_val = rxs;
  end
`endif

  // Frame FSM: start detection, centre sampling of data bits and stop-bit checking.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push        = 1'b0;
    set_frame   = 1'b0;
    set_overrun = 1'b0;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (!rxs) begin
            tick_d  = '0;
            state_d = ST_START;
          end
        end
        ST_START: begin
          if (tick_q == START_TICK) begin
            if (bit_val) begin
              state_d = ST_IDLE;
            end else begin
              tick_d    = '0;
              bit_cnt_d = '0;
              state_d   = ST_DATA;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        ST_DATA: begin
          if (tick_q == TICK_LAST) begin
            shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              state_d   = ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        ST_STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            state_d = ST_IDLE;
            if (!bit_val) begin
              set_frame = 1'b1;
            end else if (!fifo_full || rd_en) begin
              push = 1'b1;
            end else begin
              set_overrun = 1'b1;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags: a read clears them, but a new error in the same cycle wins.
  always_comb begin
    frame_err_d   = set_frame | (frame_err_q & ~rd_en);
    overrun_err_d = set_overrun | (overrun_err_q & ~rd_en);
  end

  // Circular buffer bookkeeping; push and pop together leave the count unchanged.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sync_q        <= 2'b11;
      tick_q        <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      tick_q        <= tick_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  // FIFO storage and pointers; storage is cleared so rx_data reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rx_data     = mem_q[rd_ptr_q];
  assign rda         = !fifo_empty;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule
